mdu_seq: RTL and testbench

- Iterative multiply/divide unit for the RV32M extension. Parametrised successor to the single-cycle integer ALU.
- Sits beside the ALU in the execute stage. The pipeline stalls on its valid/ready handshake.
- Computes the 8 M-extension operations, one result bit per cycle. Output is held until consumed. Supports flush.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/mdu_divstep.sv | 21 ++
 rtl/mdu_seq.sv | 153 +++++++++++++++
 tb/tb_mdu_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and operand-classification helpers for the RV32M multiply/divide unit.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_t;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

   function automatic logic is_div(mdu_op_t op);
      return op[2];
   endfunction

   function automatic logic is_rem(mdu_op_t op);
      return op[2] & op[1];
   endfunction

   function automatic logic is_signed_a(mdu_op_t op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(mdu_op_t op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_dvd_bit,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;

   assign w_shift = {i_rem, i_dvd_bit};
   // Extra top bit acts as the borrow: set means the trial subtract failed.
   assign w_diff  = {1'b0, w_shift} - {2'b00, i_dvs};
   assign o_qbit  = ~w_diff[WIDTH+1];
   assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
// Optional MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish at the accept edge.
module mdu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero_flag
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   mdu_state_t         r_state, w_state_nxt;
   mdu_op_t            r_op, w_op;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_opnd, r_out;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg, r_neg_rem, r_zero;

   logic               w_accept, w_sa, w_sb, w_b_zero, w_early;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_early_res;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;
   logic [WIDTH-1:0]   w_drem, w_quo, w_rem, w_fix;
   logic               w_qbit;

   assign w_op     = mdu_op_t'(op);
   assign w_sa     = is_signed_a(w_op) & a[WIDTH-1];
   assign w_sb     = is_signed_b(w_op) & b[WIDTH-1];
   assign w_abs_a  = w_sa ? -a : a;
   assign w_abs_b  = w_sb ? -b : b;
   assign w_b_zero = (b == '0);
   assign w_accept = in_valid && (r_state == IDLE) && !flush;

`ifdef MDU_EARLY_OUT_EN
   logic w_ovf;
   assign w_ovf = is_signed_a(w_op) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
   always_comb begin
      w_early     = 1'b0;
      w_early_res = '0;
      if (is_div(w_op)) begin
         if (w_b_zero) begin
            w_early     = 1'b1;
            w_early_res = is_rem(w_op) ? a : '1;
         end else if (w_ovf) begin
            w_early     = 1'b1;
            w_early_res = is_rem(w_op) ? '0 : a;
         end
      end else if ((a == '0) || w_b_zero) begin
         w_early = 1'b1;
      end
   end
`else
   assign w_early     = 1'b0;
   assign w_early_res = '0;
`endif

   // Multiply: LSB-first shift-add, multiplier sits in the low half of r_acc.
   assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

   // Divide: remainder in the high half, dividend shifts out / quotient shifts in low half.
   mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
      .i_dvd_bit (r_acc[WIDTH-1]),
      .i_dvs     (r_opnd),
      .o_rem     (w_drem),
      .o_qbit    (w_qbit)
   );
   assign w_div_nxt = {w_drem, r_acc[WIDTH-2:0], w_qbit};

   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_fix = '0;
      if (is_div(r_op))           w_fix = is_rem(r_op) ? w_rem : w_quo;
      else if (r_op == OP_MUL)    w_fix = w_prod[WIDTH-1:0];
      else                        w_fix = w_prod[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (w_accept) w_state_nxt = w_early ? DONE : CALC;
         end
         CALC: if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
         FIX:  w_state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (flush) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= OP_MUL;
         r_cnt     <= '0;
         r_opnd    <= '0;
         r_acc     <= '0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_out     <= '0;
         r_zero    <= 1'b1;
      end else if (w_accept) begin
         r_op      <= w_op;
         r_cnt     <= '0;
         r_opnd    <= is_div(w_op) ? w_abs_b : w_abs_a;
         r_acc     <= {{WIDTH{1'b0}}, (is_div(w_op) ? w_abs_a : w_abs_b)};
         // Divide-by-zero quotient must stay all ones, so never negate it.
         r_neg     <= (w_sa ^ w_sb) & ~(is_div(w_op) & w_b_zero);
         r_neg_rem <= w_sa;
         if (w_early) begin
            r_out  <= w_early_res;
            r_zero <= (w_early_res == '0);
         end
      end else if (r_state == CALC && !flush) begin
         r_acc <= is_div(r_op) ? w_div_nxt : w_mul_nxt;
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == FIX && !flush) begin
         r_out  <= w_fix;
         r_zero <= (w_fix == '0);
      end
   end

   assign out       = r_out;
   assign zero_flag = r_zero;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: reference results from native 64-bit arithmetic.
module tb_mdu_seq;

   localparam int W = 32;

   logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic         in_ready, out_valid, zero_flag;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0, b = '0, out;

   int           checks = 0, failures = 0;
   logic [31:0]  exp_q[$];
   int           lat_q[$];
   logic [31:0]  last_out = 32'h0;

   always #5 clk = ~clk;

   mdu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero_flag (zero_flag)
   );

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy, p;
      logic        [63:0] u;
      logic signed [31:0] x32, y32;
      sx  = {{32{x[31]}}, x};
      sy  = {{32{y[31]}}, y};
      x32 = x;
      y32 = y;
      case (o)
         3'd0: begin u = {32'h0, x} * {32'h0, y}; return u[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * $signed({32'h0, y}); return p[63:32]; end
         3'd3: begin u = {32'h0, x} * {32'h0, y}; return u[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            return x32 / y32;
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            return x32 % y32;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_EARLY_OUT_EN
      if (o[2] && y == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      if (!o[2] && (x == 0 || y == 0)) return 1;
`endif
      return W + 2;
   endfunction

   // Presents one request at a negedge and returns at the negedge right after the accept edge.
   task automatic drive_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic push, input logic [31:0] e);
      int n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin
         failures++;
         $display("FAIL drive_wait_ready: in_ready=%b required=1 after %0d cycles", in_ready, n);
      end
      if (push) begin exp_q.push_back(e); lat_q.push_back(exp_lat(o, x, y)); end
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      op = 3'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out !== 32'h0)      begin failures++; $display("FAIL reset_out: got %h want 0", out); end
      checks++; if (zero_flag !== 1'b1) begin failures++; $display("FAIL reset_zero_flag: got %b want 1", zero_flag); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ops();
      logic [2:0]  t_op[$];
      logic [31:0] t_a[$], t_b[$], t_e[$];
      logic [31:0] e, x, y;
      int          l, n;
      t_op = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
               3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd5};
      t_a  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
               32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF};
      t_b  = '{32'd3, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h1234_5678, 32'd1};
      t_e  = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF};
      for (int i = 0; i < 10; i++) begin
         x = $urandom;
         y = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
         t_op.push_back(3'(i % 8)); t_a.push_back(x); t_b.push_back(y);
         t_e.push_back(model(3'(i % 8), x, y));
      end
      for (int i = 0; i < t_op.size(); i++) begin
         drive_op(t_op[i], t_a[i], t_b[i], 1'b1, t_e[i]);
         n = 1;
         while (!out_valid && n < 64) begin @(negedge clk); n++; end
         e = exp_q.pop_front();
         l = lat_q.pop_front();
         checks++; if (n !== l) begin failures++; $display("FAIL op%0d_latency: got %0d edges want %0d", i, n, l); end
         checks++; if (out !== e) begin failures++; $display("FAIL op%0d_out: op=%0d got %h want %h", i, t_op[i], out, e); end
         checks++; if (zero_flag !== (e == 0)) begin failures++; $display("FAIL op%0d_zero_flag: got %b want %b", i, zero_flag, e == 0); end
         last_out = e;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      int          n = 1;
      drive_op(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
      while (!out_valid && n < 64) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      void'(lat_q.pop_front());
      op = 3'd0; a = 32'd3; b = 32'd3; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, out_valid); end
         checks++; if (out !== e)          begin failures++; $display("FAIL bp_hold_out[%0d]: got %h want %h", k, out, e); end
         checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", k, in_ready); end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      last_out = e;
      checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL bp_no_stale_accept: in_ready=%b want 1", in_ready); end
   endtask

   task automatic test_flush_reset();
      logic saw_valid = 1'b0;
      int   n = 1;
      drive_op(3'd4, 32'd1000, 32'd7, 1'b0, 32'h0);
      repeat (10) begin saw_valid |= out_valid; @(negedge clk); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
      checks++; if (out !== last_out)  begin failures++; $display("FAIL flush_out_kept: got %h want %h", out, last_out); end
      flush = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'd8; b = 32'd2;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_blocks_accept: in_ready=%b want 1", in_ready); end
      drive_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);
      repeat (5) begin saw_valid |= out_valid; @(negedge clk); end
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
      checks++; if (out !== 32'h0)      begin failures++; $display("FAIL rst_mid_out: got %h want 0", out); end
      checks++; if (zero_flag !== 1'b1) begin failures++; $display("FAIL rst_mid_zero_flag: got %b want 1", zero_flag); end
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid |= out_valid;
      checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL flush_rst_out_valid_seen: got %b want 0", saw_valid); end
      drive_op(3'd5, 32'd9, 32'd3, 1'b1, 32'd3);
      while (!out_valid && n < 64) begin @(negedge clk); n++; end
      checks++; if (n !== lat_q.pop_front()) begin failures++; $display("FAIL after_rst_latency: got %0d edges want %0d", n, W + 2); end
      checks++; if (out !== exp_q.pop_front()) begin failures++; $display("FAIL after_rst_divu: got %h want 3", out); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ops();
      test_backpressure();
      test_flush_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
